voice_allocator: RTL and testbench
==================================

# voice_allocator

Polyphonic voice scheduler between the MIDI front end and the synth voice bank. Accepts one decoded 3-byte MIDI channel-0 event at a time over a valid/ready handshake and assigns NOTE_ON pitches to `NUM_VOICES` synth voices. Reuses a voice already holding the same pitch, then a free voice, and otherwise steals the least-recently-allocated voice. Drives per-voice gate, pitch, velocity and a one-cycle retrigger pulse; phase-increment lookup stays downstream in each voice.

## Interface
- `NUM_VOICES`, default 4: number of voices; power of two, 2..8.
- `clk_in` in 1: system clock.
- `rst_in` in 1: reset; one clock, synchronous and active-high.
- `midi_event_in` in `MIDI_BYTES` (24): [23:16] status, [15:8] data1 (note/controller), [7:0] data2 (velocity/value).
- `midi_valid_in` in 1: event present.
- `midi_ready_out` out 1: allocator can accept; transfer occurs when valid && ready.
- `voice_gate_out` out `NUM_VOICES`: voice i sounding.
- `voice_pitch_out` out `NUM_VOICES`x8: MIDI note per voice; held after release.
- `voice_vel_out` out `NUM_VOICES`x8: velocity per voice.
- `voice_trig_out` out `NUM_VOICES`: one-cycle pulse when voice i (re)starts a note.

## Operation
- FSM states IDLE → SEARCH → COMMIT → IDLE. `midi_ready_out` is 1 only in IDLE.
- IDLE: on handshake, register the event and go to SEARCH.
- Event classification:
  - NOTE_ON (8'h90), data2≠0: note-on.
  - NOTE_ON with data2=0, or NOTE_OFF (8'h80): note-off.
  - CC (8'hB0) with data1=123: all-notes-off.
  - Anything else: no-op; still passes through SEARCH and COMMIT with no state change.
- Valid note range is 12..119 (the note table covers 108 entries starting at MIDI 12). Out-of-range note-on and note-off are no-ops.
- SEARCH, note-on, first match wins:
  - Lowest-index gated voice with equal pitch: retrigger it.
  - Else lowest-index voice with gate=0: use it.
  - Else the voice with LRU rank `NUM_VOICES`-1: steal it.
- SEARCH, note-off: lowest-index gated voice with equal pitch. If none, no-op.
- COMMIT:
  - Note-on target: gate=1, pitch=data1, vel=data2, trig pulse; the target's LRU rank becomes 0.
  - Note-off target: gate=0; pitch and vel are unchanged.
  - All-notes-off: every gate=0, no trig.
- LRU ranks are a permutation of 0..`NUM_VOICES`-1. On allocation of voice v with old rank r, every voice with rank < r increments and v becomes 0. Note-off does not change ranks.
- Only one event is in flight at a time; the handshake prevents overlapping events.

## Timing
- Handshake at edge T. SEARCH occupies cycle T+1, COMMIT occupies cycle T+2.
- Voice outputs and `voice_trig_out` change at edge T+3. `voice_trig_out` is high for exactly cycle T+3.
- `midi_ready_out` is low during T+1..T+2 and high again from T+3. Throughput is one event per 3 cycles.
- Reset values:
  - `midi_ready_out`=1, FSM=IDLE.
  - All gate/pitch/vel/trig = 0.
  - Rank of voice i = i, so voice `NUM_VOICES`-1 is the first to be stolen.
- Reset in SEARCH or COMMIT aborts the event with no voice update; the next cycle is IDLE with reset values.
- `midi_valid_in` while not ready is ignored; the source holds the event until ready.

## Structure
- In the shared `constants` package:
  - `NOTE_ON`, `NOTE_OFF`, `CC`, `CC_ALL_NOTES_OFF` (123).
  - `MIDI_NOTE_MIN` (12), `MIDI_NOTE_MAX` (119).
  - `typedef struct packed {logic gate; logic [7:0] pitch; logic [7:0] vel;} voice_t`.
- Sub-module `voice_lru`:
  - Holds the rank registers.
  - Input `touch_valid`/`touch_idx`; output `oldest_idx`.
  - Resets with the same `rst_in`.
- Search logic is a pure priority encoder registered at the end of SEARCH. Width of index and rank is $clog2(`NUM_VOICES`).

## Test plan
- Reset, `NUM_VOICES`=4, NOTE_ON 60 vel 100:
  - Voice 0 gate=1, pitch=60, vel=100 at T+3, `voice_trig_out`=4'b0001 for one cycle.
  - `midi_ready_out` low for exactly 2 cycles.
- NOTE_ON 60, 62, 64, 67, then 72:
  - Voices 0..3 fill in order.
  - 72 steals voice 0 (oldest); trig=4'b0001, pitch[0]=72.
- NOTE_ON 60 vel 100, then NOTE_ON 60 vel 50:
  - Voice 0 retriggered with vel=50, trig pulse; voice 1 stays gate=0.
- NOTE_ON 60, then NOTE_ON 60 vel 0:
  - Gate[0]=0, pitch[0] stays 60, no trig.
  - A following NOTE_ON 64 reuses voice 0.
- Four notes on, then CC 123: all gates 0.
- Invalid events, each -> no output change, ready back after 3 cycles:
  - NOTE_ON note 5.
  - PITCH_BEND 8'hE0.
  - NOTE_OFF for an unheld pitch.
- Reset asserted mid-SEARCH during a note-on: outputs stay at reset values, ready=1 on the next cycle.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared constants, voice payload type and MIDI event classification for the voice allocator.
package voice_allocator_pkg;

    localparam int unsigned MIDI_BYTES = 24;

    localparam logic [7:0] NOTE_ON          = 8'h90;
    localparam logic [7:0] NOTE_OFF         = 8'h80;
    localparam logic [7:0] CC               = 8'hB0;
    localparam logic [7:0] CC_ALL_NOTES_OFF = 8'd123;
    localparam logic [7:0] MIDI_NOTE_MIN    = 8'd12;
    localparam logic [7:0] MIDI_NOTE_MAX    = 8'd119;

    typedef struct packed {
        logic       gate;
        logic [7:0] pitch;
        logic [7:0] vel;
    } voice_t;

    // What an accepted event does to the voice bank
    typedef enum logic [1:0] {
        EV_NOP     = 2'd0,
        EV_ON      = 2'd1,
        EV_OFF     = 2'd2,
        EV_ALL_OFF = 2'd3
    } ev_kind_t;

    // Decode a 3-byte channel-0 event; out-of-range notes collapse to a no-op
    function automatic ev_kind_t classify(input logic [MIDI_BYTES-1:0] ev);
        logic [7:0] status;
        logic [7:0] data1;
        logic [7:0] data2;
        logic       in_range;
        ev_kind_t   kind;
        status   = ev[23:16];
        data1    = ev[15:8];
        data2    = ev[7:0];
        in_range = (data1 >= MIDI_NOTE_MIN) && (data1 <= MIDI_NOTE_MAX);
        kind     = EV_NOP;
        if (status == NOTE_ON && data2 != 8'd0) begin
            kind = in_range ? EV_ON : EV_NOP;
        end else if (status == NOTE_ON || status == NOTE_OFF) begin
            kind = in_range ? EV_OFF : EV_NOP;
        end else if (status == CC && data1 == CC_ALL_NOTES_OFF) begin
            kind = EV_ALL_OFF;
        end
        return kind;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// MIDI event valid/ready channel from the front end into the allocator.
interface voice_allocator_if;
    import voice_allocator_pkg::*;

    logic [MIDI_BYTES-1:0] midi_event_in;
    logic                  midi_valid_in;
    logic                  midi_ready_out;

    modport master (output midi_event_in, output midi_valid_in, input  midi_ready_out);
    modport slave  (input  midi_event_in, input  midi_valid_in, output midi_ready_out);

endinterface

// File: rtl/voice_allocator_lru.sv
// LRU rank keeper: rank 0 is the most recently allocated voice, the highest rank is stolen first.
module voice_lru #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             touch_valid,
    input  logic [IDX_W-1:0] touch_idx,
    output logic [IDX_W-1:0] oldest_idx
);

    logic [NUM_VOICES-1:0][IDX_W-1:0] rank;
    logic [NUM_VOICES-1:0][IDX_W-1:0] rank_next;
    logic [IDX_W-1:0]                 oldest_next;

    // Promote the touched voice to rank 0 and age everything that was younger than it
    always_comb begin
        rank_next = rank;
        if (touch_valid) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (rank[i] < rank[touch_idx]) begin
                    rank_next[i] = rank[i] + IDX_W'(1);
                end
            end
            rank_next[touch_idx] = '0;
        end
        oldest_next = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (rank_next[i] == IDX_W'(NUM_VOICES - 1)) begin
                oldest_next = IDX_W'(i);
            end
        end
    end

    // Rank registers; oldest index is registered alongside so it is ready for the next search
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                rank[i] <= IDX_W'(i);
            end
            oldest_idx <= IDX_W'(NUM_VOICES - 1);
        end else begin
            rank       <= rank_next;
            oldest_idx <= oldest_next;
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: one MIDI event at a time, IDLE -> SEARCH -> COMMIT -> IDLE.
module voice_allocator
    import voice_allocator_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    voice_allocator_if.slave           midi,
    output logic [NUM_VOICES-1:0]      voice_gate_out,
    output logic [NUM_VOICES-1:0][7:0] voice_pitch_out,
    output logic [NUM_VOICES-1:0][7:0] voice_vel_out,
    output logic [NUM_VOICES-1:0]      voice_trig_out
);

    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [1:0]                  state, state_next;
    logic                        ready, ready_next;
    ev_kind_t                    kind_q, kind_next;
    logic [7:0]                  note_q, note_next;
    logic [7:0]                  vel_q, vel_next;
    logic [IDX_W-1:0]            tgt_idx, tgt_next;
    logic                        tgt_hit, hit_next;
    voice_t [NUM_VOICES-1:0]     voices, voices_next;
    logic [NUM_VOICES-1:0]       trig_q, trig_next;

    logic                        match_hit, free_hit;
    logic [IDX_W-1:0]            match_idx, free_idx;
    logic [IDX_W-1:0]            oldest_idx;
    logic                        touch_valid;

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_lru (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .touch_valid (touch_valid),
        .touch_idx   (tgt_idx),
        .oldest_idx  (oldest_idx)
    );

    // Priority encoders: lowest-index sounding voice on this pitch, lowest-index silent voice
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voices[i].gate && voices[i].pitch == note_q) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!voices[i].gate) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and datapath: capture in IDLE, pick a target in SEARCH, apply it in COMMIT
    always_comb begin
        state_next  = state;
        kind_next   = kind_q;
        note_next   = note_q;
        vel_next    = vel_q;
        tgt_next    = tgt_idx;
        hit_next    = tgt_hit;
        voices_next = voices;
        trig_next   = '0;
        touch_valid = 1'b0;

        case (state)
            ST_IDLE: begin
                if (midi.midi_valid_in && ready) begin
                    kind_next  = classify(midi.midi_event_in);
                    note_next  = midi.midi_event_in[15:8];
                    vel_next   = midi.midi_event_in[7:0];
                    state_next = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                hit_next = 1'b0;
                tgt_next = '0;
                case (kind_q)
                    EV_ON: begin
                        hit_next = 1'b1;
                        if (match_hit) begin
                            tgt_next = match_idx;
                        end else if (free_hit) begin
                            tgt_next = free_idx;
                        end else begin
                            tgt_next = oldest_idx;
                        end
                    end
                    EV_OFF: begin
                        hit_next = match_hit;
                        tgt_next = match_idx;
                    end
                    default: ;
                endcase
                state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (tgt_hit && kind_q == EV_ON) begin
                    voices_next[tgt_idx].gate  = 1'b1;
                    voices_next[tgt_idx].pitch = note_q;
                    voices_next[tgt_idx].vel   = vel_q;
                    trig_next[tgt_idx]         = 1'b1;
                    touch_valid                = 1'b1;
                end else if (tgt_hit && kind_q == EV_OFF) begin
                    voices_next[tgt_idx].gate = 1'b0;
                end
                if (kind_q == EV_ALL_OFF) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        voices_next[i].gate = 1'b0;
                    end
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        ready_next = (state_next == ST_IDLE);
    end

    // State, event capture, target and voice registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            kind_q  <= EV_NOP;
            note_q  <= '0;
            vel_q   <= '0;
            tgt_idx <= '0;
            tgt_hit <= 1'b0;
            voices  <= '0;
            trig_q  <= '0;
        end else begin
            state   <= state_next;
            ready   <= ready_next;
            kind_q  <= kind_next;
            note_q  <= note_next;
            vel_q   <= vel_next;
            tgt_idx <= tgt_next;
            tgt_hit <= hit_next;
            voices  <= voices_next;
            trig_q  <= trig_next;
        end
    end

    // Unpack voice registers onto the per-voice output buses
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_gate_out[i]  = voices[i].gate;
            voice_pitch_out[i] = voices[i].pitch;
            voice_vel_out[i]   = voices[i].vel;
        end
    end

    assign voice_trig_out      = trig_q;
    assign midi.midi_ready_out = ready;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed plus random bench for voice_allocator against a list-based LRU voice model.
module tb_voice_allocator;
    import voice_allocator_pkg::*;

    localparam int unsigned NV = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NV-1:0]      gate;
    logic [NV-1:0][7:0] pitch;
    logic [NV-1:0][7:0] vel;
    logic [NV-1:0]      trig;

    int n_cmp  = 0;
    int n_fail = 0;

    voice_allocator_if bus ();

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .midi            (bus),
        .voice_gate_out  (gate),
        .voice_pitch_out (pitch),
        .voice_vel_out   (vel),
        .voice_trig_out  (trig)
    );

    always #5 clk = ~clk;

    // Reference model: per-voice arrays plus an allocation-order list (front = most recent)
    logic          m_gate  [NV];
    logic [7:0]    m_pitch [NV];
    logic [7:0]    m_vel   [NV];
    logic [NV-1:0] m_trig;
    int            lru_q[$];

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 1'b0; m_pitch[i] = 8'd0; m_vel[i] = 8'd0;
        end
        m_trig = '0;
        lru_q.delete();
        for (int i = 0; i < NV; i++) lru_q.push_back(i);
    endtask

    task automatic model_apply(input logic [23:0] ev);
        logic [7:0] st, d1, d2;
        int v;
        bit in_rng;
        st = ev[23:16]; d1 = ev[15:8]; d2 = ev[7:0];
        in_rng = (d1 >= 8'd12) && (d1 <= 8'd119);
        m_trig = '0;
        v = -1;
        if (st == 8'h90 && d2 != 8'd0) begin
            if (in_rng) begin
                for (int i = 0; i < NV; i++) if (v < 0 && m_gate[i] && m_pitch[i] == d1) v = i;
                for (int i = 0; i < NV; i++) if (v < 0 && !m_gate[i]) v = i;
                if (v < 0) v = lru_q[lru_q.size() - 1];
                m_gate[v] = 1'b1; m_pitch[v] = d1; m_vel[v] = d2; m_trig[v] = 1'b1;
                for (int k = 0; k < lru_q.size(); k++) begin
                    if (lru_q[k] == v) begin lru_q.delete(k); break; end
                end
                lru_q.push_front(v);
            end
        end else if (st == 8'h90 || st == 8'h80) begin
            if (in_rng) begin
                for (int i = 0; i < NV; i++) if (v < 0 && m_gate[i] && m_pitch[i] == d1) v = i;
                if (v >= 0) m_gate[v] = 1'b0;
            end
        end else if (st == 8'hB0 && d1 == 8'd123) begin
            for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
        end
    endtask

    function automatic logic [NV-1:0] m_gates();
        logic [NV-1:0] g;
        for (int i = 0; i < NV; i++) g[i] = m_gate[i];
        return g;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_voices(input string tag);
        check({tag, " gates"}, 32'(gate), 32'(m_gates()));
        for (int i = 0; i < NV; i++) begin
            check($sformatf("%s pitch%0d", tag, i), 32'(pitch[i]), 32'(m_pitch[i]));
            check($sformatf("%s vel%0d", tag, i), 32'(vel[i]), 32'(m_vel[i]));
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check({tag, " ready"}, 32'(bus.midi_ready_out), 32'd1);
        check({tag, " trig"}, 32'(trig), 32'd0);
        check_voices(tag);
    endtask

    // Full transaction: handshake at T, checks at T+1, T+2, T+3, T+4
    task automatic send(input logic [23:0] ev, input string tag);
        int waited = 0;
        while (bus.midi_ready_out !== 1'b1 && waited < 10) begin
            @(posedge clk); #1; waited++;
        end
        check({tag, " ready idle"}, 32'(bus.midi_ready_out), 32'd1);
        bus.midi_event_in = ev;
        bus.midi_valid_in = 1'b1;
        @(posedge clk); #1;
        bus.midi_valid_in = 1'b0;
        check({tag, " ready T+1"}, 32'(bus.midi_ready_out), 32'd0);
        @(posedge clk); #1;
        check({tag, " ready T+2"}, 32'(bus.midi_ready_out), 32'd0);
        check({tag, " gates T+2"}, 32'(gate), 32'(m_gates()));
        model_apply(ev);
        @(posedge clk); #1;
        check({tag, " ready T+3"}, 32'(bus.midi_ready_out), 32'd1);
        check({tag, " trig T+3"}, 32'(trig), 32'(m_trig));
        check_voices(tag);
        @(posedge clk); #1;
        check({tag, " trig T+4"}, 32'(trig), 32'd0);
    endtask

    function automatic logic [23:0] mk(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2);
        return {st, d1, d2};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] ev;
        int sel;
        rst = 1'b1;
        bus.midi_event_in = '0;
        bus.midi_valid_in = 1'b0;
        model_reset();

        // Single note-on after reset
        do_reset("rst0");
        send(mk(8'h90, 8'd60, 8'd100), "on60");
        check("on60 gate0 const", 32'(gate), 32'h1);

        // Fill all voices then steal the oldest
        do_reset("rst1");
        send(mk(8'h90, 8'd60, 8'd90), "fill60");
        send(mk(8'h90, 8'd62, 8'd91), "fill62");
        send(mk(8'h90, 8'd64, 8'd92), "fill64");
        send(mk(8'h90, 8'd67, 8'd93), "fill67");
        send(mk(8'h90, 8'd72, 8'd94), "steal72");
        check("steal72 pitch0 const", 32'(pitch[0]), 32'd72);

        // Retrigger same pitch
        do_reset("rst2");
        send(mk(8'h90, 8'd60, 8'd100), "re60a");
        send(mk(8'h90, 8'd60, 8'd50), "re60b");
        check("re60b vel0 const", 32'(vel[0]), 32'd50);

        // Note-on velocity 0 releases, next note reuses the voice
        do_reset("rst3");
        send(mk(8'h90, 8'd60, 8'd100), "rel60");
        send(mk(8'h90, 8'd60, 8'd0), "rel60v0");
        check("rel60v0 pitch0 held", 32'(pitch[0]), 32'd60);
        send(mk(8'h90, 8'd64, 8'd80), "reuse64");

        // All-notes-off
        do_reset("rst4");
        send(mk(8'h90, 8'd40, 8'd10), "ano40");
        send(mk(8'h90, 8'd41, 8'd11), "ano41");
        send(mk(8'h90, 8'd42, 8'd12), "ano42");
        send(mk(8'h90, 8'd43, 8'd13), "ano43");
        send(mk(8'hB0, 8'd123, 8'd0), "cc123");
        check("cc123 gates const", 32'(gate), 32'd0);

        // Invalid events leave the bank untouched
        send(mk(8'h90, 8'd61, 8'd70), "pre_inv");
        send(mk(8'h90, 8'd5, 8'd70), "on_note5");
        send(mk(8'h90, 8'd120, 8'd70), "on_note120");
        send(mk(8'hE0, 8'd0, 8'd64), "bend");
        send(mk(8'h80, 8'd99, 8'd0), "off_unheld");
        send(mk(8'h90, 8'd12, 8'd1), "on_min");
        send(mk(8'h90, 8'd119, 8'd127), "on_max");

        // Reset during SEARCH aborts the note-on
        do_reset("rst5");
        bus.midi_event_in = mk(8'h90, 8'd60, 8'd100);
        bus.midi_valid_in = 1'b1;
        @(posedge clk); #1;
        bus.midi_valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort ready", 32'(bus.midi_ready_out), 32'd1);
        check("abort trig", 32'(trig), 32'd0);
        check_voices("abort");
        @(posedge clk); #1;
        check("abort trig late", 32'(trig), 32'd0);
        check("abort gates late", 32'(gate), 32'd0);
        send(mk(8'h90, 8'd48, 8'd33), "post_abort");

        // Random traffic with colliding pitches
        do_reset("rst6");
        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2, 3, 4: ev = mk(8'h90, 8'($urandom_range(58, 66)), 8'($urandom_range(1, 127)));
                5:             ev = mk(8'h90, 8'($urandom_range(58, 66)), 8'd0);
                6, 7:          ev = mk(8'h80, 8'($urandom_range(58, 66)), 8'($urandom_range(0, 127)));
                8:             ev = ($urandom_range(0, 3) == 0) ? mk(8'hB0, 8'd123, 8'd0)
                                                                : mk(8'hB0, 8'd7, 8'($urandom_range(0, 127)));
                default:       ev = ($urandom_range(0, 1) == 0) ? mk(8'hE0, 8'($urandom_range(0, 127)), 8'd64)
                                                                : mk(8'h90, 8'($urandom_range(120, 127)), 8'd90);
            endcase
            send(ev, $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
